core_sequencer: RTL
===================

# core_sequencer

Multi-cycle control FSM for the core's RV32I subset (OP, OP-IMM, LOAD, STORE). Sits beside the datapath and sequences fetch, decode, execute, memory and writeback over a shared single-port memory with a req/ready handshake. Drives the datapath enables and the `imm_op` select consumed by the sign-extension unit. Any unsupported opcode sends it to a sticky trap.

## Interface
- `DATA_WIDTH`, 32: width of `retired_count`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: `instruction[6:0]` from the instruction register; sampled only in DECODE.
- `mem_ready` in 1: memory accepted/completed the current request; ignored while `mem_req`=0.
- `mem_req` out 1: memory request; held high until `mem_ready` is sampled high.
- `mem_sel` out 1: 0 = instruction fetch address (PC), 1 = data address (ALU result).
- `mem_we` out 1: store request; valid only with `mem_req`.
- `ir_we` out 1: load the instruction register.
- `pc_we` out 1: PC <= PC+4.
- `imm_op` out 3: immediate select (isa_shared): IMM_NONE=3'd0, IMM_3120=3'd1, IMM_S=3'd2.
- `alu_src_b` out 1: 0 = rs2, 1 = sign-extended immediate.
- `reg_we` out 1: register-file write enable.
- `wb_sel` out 1: 0 = ALU result, 1 = memory read data.
- `illegal` out 1: sticky trap flag.
- `retired_count` out DATA_WIDTH: instructions retired since reset.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- While `rst`=1, all outputs are 0, `retired_count`=0 and the latched opcode is cleared.
- FETCH: `mem_req`=1 and `mem_sel`=0.
  - If `mem_ready`=0, stay in FETCH.
  - If `mem_ready`=1, pulse `ir_we`=1 and `pc_we`=1 in the same cycle, then go to DECODE.
- DECODE: latch `opcode` internally.
  - 0110011, 0010011, 0000011 and 0100011 go to EXEC.
  - Any other value goes to TRAP.
  - All outputs are 0 in this state.
- EXEC: `imm_op` and `alu_src_b` are driven from the latched opcode:
  - OP: IMM_NONE, 0. Next state WB.
  - OP-IMM: IMM_3120, 1. Next state WB.
  - LOAD: IMM_3120, 1. Next state MEM.
  - STORE: IMM_S, 1. Next state MEM.
- MEM: `mem_req`=1, `mem_sel`=1, `mem_we`=1 for STORE only. `imm_op` and `alu_src_b` hold their EXEC values so the address stays stable.
  - Stay in MEM until `mem_ready`=1.
  - STORE then goes to FETCH and increments `retired_count`.
  - LOAD then goes to WB.
- WB: `reg_we`=1 for exactly one cycle. `wb_sel`=1 for LOAD, 0 otherwise. `retired_count` increments. Next state FETCH.
- TRAP: `illegal`=1. All other outputs are 0. Stays in TRAP until `rst`.
- `retired_count` wraps modulo 2^DATA_WIDTH.
- Outputs are a Moore decode of state plus latched opcode. The exceptions are `ir_we` and `pc_we`, which are qualified by `mem_ready`.

## Timing
- Cycles per instruction with zero-wait memory (`mem_ready` high on the first request cycle):
  - OP/OP-IMM: 4 (FETCH, DECODE, EXEC, WB).
  - STORE: 4 (FETCH, DECODE, EXEC, MEM).
  - LOAD: 5.
- Each wait cycle on `mem_ready` adds one cycle. There is no timeout.
- `mem_req`, `mem_sel` and `mem_we` stay stable from assertion until the cycle in which `mem_ready`=1. They deassert, or change, on the next cycle.
- Back-to-back requests are allowed: STORE MEM at cycle n is followed by FETCH `mem_req`=1 at cycle n+1.
- `mem_ready`=1 in DECODE, EXEC, WB or TRAP has no effect.
- The opcode is latched at the DECODE edge. Changes on `opcode` after that edge do not affect EXEC, MEM or WB.
- `rst` asserted in any state, including mid-handshake in FETCH or MEM: the next cycle is FETCH with all outputs 0 while `rst` is held. An abandoned request is dropped with no `ir_we`, `pc_we`, `reg_we` or count increment.
- The first cycle after `rst` deasserts is FETCH with `mem_req`=1.

## Test plan
- Reset, then an OP (0110011) fetch with `mem_ready` tied high:
  - Required trace: `mem_req`/`ir_we`/`pc_we` at cycle 0, EXEC `imm_op`=0 and `alu_src_b`=0 at cycle 2, `reg_we`=1 and `wb_sel`=0 at cycle 3.
  - `retired_count`=1 at cycle 4.
- LOAD (0000011) with 2 wait cycles on the data access:
  - `mem_sel`=1 and `mem_we`=0 are held for 3 cycles while `imm_op`=1 stays stable.
  - WB follows with `wb_sel`=1. Total instruction time is 7 cycles.
- STORE (0100011):
  - EXEC shows `imm_op`=2. MEM shows `mem_we`=1.
  - No `reg_we` at any point. The next cycle is FETCH.
  - `retired_count` increments by 1.
- Opcode 1101111:
  - TRAP is entered after DECODE. `illegal`=1 persists for 20 cycles with `mem_req`=0.
  - `rst` then clears `illegal` and restarts FETCH.
- Assert `rst` during a FETCH wait, and again during a MEM wait:
  - Required response: `mem_req`=0 the next cycle and no enable pulses.
  - `retired_count` stays 0 after restart.
- Preload `retired_count` near wrap (force 32'hFFFFFFFF), then run one OP:
  - Required response: `retired_count`=0.
  - Also toggle `opcode` during EXEC and check that `imm_op` does not change.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Control bundle between core_sequencer (master) and the datapath/memory side (slave).
interface core_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [6:0]            opcode;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_sel;
  logic                  mem_we;
  logic                  ir_we;
  logic                  pc_we;
  logic [2:0]            imm_op;
  logic                  alu_src_b;
  logic                  reg_we;
  logic                  wb_sel;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] retired_count;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_sel, mem_we, ir_we, pc_we, imm_op, alu_src_b,
           reg_we, wb_sel, illegal, retired_count
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_sel, mem_we, ir_we, pc_we, imm_op, alu_src_b,
           reg_we, wb_sel, illegal, retired_count
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I-subset control FSM: fetch/decode/exec/mem/wb over a shared
// single-port memory, with a sticky trap on unsupported opcodes.
module core_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  core_sequencer_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_3120 = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] opc_q, opc_d;
  logic       retire;

  logic       is_load, is_store, is_mem;
  logic [2:0] imm_sel;
  logic       alub_sel;

  logic       mem_req_c, mem_sel_c, mem_we_c, ir_we_c, pc_we_c;
  logic [2:0] imm_op_c;
  logic       alu_src_b_c, reg_we_c, wb_sel_c, illegal_c;

  function automatic logic is_legal(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) ||
           (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // State, latched opcode and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_FETCH;
      opc_q             <= 7'd0;
      bus.retired_count <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      if (retire) begin
        bus.retired_count <= bus.retired_count + DATA_WIDTH'(1);
      end
    end
  end

  // Instruction class decode of the latched opcode
  always_comb begin
    is_load  = (opc_q == OPC_LOAD);
    is_store = (opc_q == OPC_STORE);
    is_mem   = is_load || is_store;
    alub_sel = (opc_q != OPC_OP);
    if (opc_q == OPC_OP) begin
      imm_sel = IMM_NONE;
    end else if (is_store) begin
      imm_sel = IMM_S;
    end else begin
      imm_sel = IMM_3120;
    end
  end

  // Next state and Moore outputs; ir_we/pc_we qualified by mem_ready
  always_comb begin
    state_d     = state_q;
    opc_d       = opc_q;
    retire      = 1'b0;
    mem_req_c   = 1'b0;
    mem_sel_c   = 1'b0;
    mem_we_c    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    imm_op_c    = IMM_NONE;
    alu_src_b_c = 1'b0;
    reg_we_c    = 1'b0;
    wb_sel_c    = 1'b0;
    illegal_c   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (bus.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opc_d   = bus.opcode;
        state_d = is_legal(bus.opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        imm_op_c    = imm_sel;
        alu_src_b_c = alub_sel;
        state_d     = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        mem_sel_c   = 1'b1;
        mem_we_c    = is_store;
        imm_op_c    = imm_sel;
        alu_src_b_c = alub_sel;
        if (bus.mem_ready) begin
          if (is_store) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        wb_sel_c = is_load;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset silences every output in the same cycle, abandoning any request
    if (rst) begin
      retire      = 1'b0;
      mem_req_c   = 1'b0;
      mem_sel_c   = 1'b0;
      mem_we_c    = 1'b0;
      ir_we_c     = 1'b0;
      pc_we_c     = 1'b0;
      imm_op_c    = IMM_NONE;
      alu_src_b_c = 1'b0;
      reg_we_c    = 1'b0;
      wb_sel_c    = 1'b0;
      illegal_c   = 1'b0;
    end
  end

  assign bus.mem_req   = mem_req_c;
  assign bus.mem_sel   = mem_sel_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.ir_we     = ir_we_c;
  assign bus.pc_we     = pc_we_c;
  assign bus.imm_op    = imm_op_c;
  assign bus.alu_src_b = alu_src_b_c;
  assign bus.reg_we    = reg_we_c;
  assign bus.wb_sel    = wb_sel_c;
  assign bus.illegal   = illegal_c;

endmodule
